// File: rtl/bdiv12x6_seq_pkg.sv
// Shared types and sizing helpers for the sequential 12/6 restoring divider.
// Imported by the interface, the datapath step and the top-level FSM.
package bdiv_pkg;

  localparam int W_DEF = 6;
  localparam int DW = 2 * W_DEF;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // A one-bit counter is still needed when the divider degenerates to W=1.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/bdiv12x6_seq_if.sv
// Operand/result handshake bundle for the divider.
// The master drives operands and out_ready; the slave (divider) drives results.
interface bdiv12x6_seq_if #(parameter int W = bdiv_pkg::W_DEF);

  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] P;
  logic [W-1:0]   B;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   Q;
  logic [W-1:0]   R;
  logic           ovf;
  logic           dbz;

  modport master (
    output in_valid, P, B, out_ready,
    input  in_ready, out_valid, Q, R, ovf, dbz
  );

  modport slave (
    input  in_valid, P, B, out_ready,
    output in_ready, out_valid, Q, R, ovf, dbz
  );

endinterface

// File: rtl/bdiv12x6_seq_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract B,
// and keep the difference only when it does not borrow.
module bdiv_step #(
  parameter int W = 6
) (
  input  logic [W:0]   rem_in,
  input  logic         bit_in,
  input  logic [W-1:0] b,
  output logic [W:0]   rem_out,
  output logic         q_bit
);

  logic [W+1:0] shifted;

  // The remainder stays below B, so a successful subtract always fits in W+1 bits.
  always_comb begin
    shifted = {rem_in, bit_in};
    q_bit   = (shifted >= {2'b00, b});
    rem_out = q_bit ? (shifted[W:0] - {1'b0, b}) : shifted[W:0];
  end

endmodule

// File: rtl/bdiv12x6_seq.sv
// Sequential unsigned restoring divider: 2W-bit dividend by W-bit divisor,
// one quotient bit per cycle, valid/ready handshake on both sides.
module bdiv12x6_seq
  import bdiv_pkg::*;
#(
  parameter int W = W_DEF
) (
  input logic           clk,
  input logic           rst,
  bdiv12x6_seq_if.slave bus
);

  localparam int CW = cnt_width(W);
  localparam int PW = 2 * W;

  state_t         state;
  state_t         state_next;
  logic [W-1:0]   b_reg;
  logic [W-1:0]   dvd_reg;
  logic [W-1:0]   q_reg;
  logic [W:0]     rem_reg;
  logic [CW-1:0]  cnt_reg;
  logic           ovf_reg;
  logic           dbz_reg;
  logic           out_valid_reg;

  logic           is_zero;
  logic           is_ovf;
  logic           in_ready_c;
  logic           accept;
  logic           arm_valid;
  logic           release_c;
  logic [W:0]     rem_step;
  logic           step_bit;

  assign is_zero = (bus.B == '0);
  assign is_ovf  = (bus.P[PW-1:W] >= bus.B);

  bdiv_step #(.W(W)) u_step (
    .rem_in  (rem_reg),
    .bit_in  (dvd_reg[W-1]),
    .b       (b_reg),
    .rem_out (rem_step),
    .q_bit   (step_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Flagged operations skip CALC entirely; results are held until consumed.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (bus.in_valid) state_next = (is_zero || is_ovf) ? DONE : CALC;
      CALC: if (cnt_reg == '0) state_next = DONE;
      DONE: if (out_valid_reg && bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready_c = 1'b0;
    accept     = 1'b0;
    arm_valid  = 1'b0;
    release_c  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        accept     = bus.in_valid;
      end
      DONE: begin
        arm_valid = !out_valid_reg;
        release_c = out_valid_reg && bus.out_ready;
      end
      default: ;
    endcase
  end

  // out_valid is registered, so it rises one cycle after the FSM reaches DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_reg         <= '0;
      dvd_reg       <= '0;
      q_reg         <= '0;
      rem_reg       <= '0;
      cnt_reg       <= '0;
      ovf_reg       <= 1'b0;
      dbz_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      if (accept) begin
        b_reg   <= bus.B;
        dbz_reg <= is_zero;
        ovf_reg <= !is_zero && is_ovf;
        if (is_zero || is_ovf) begin
          q_reg   <= '1;
          rem_reg <= '0;
          dvd_reg <= '0;
          cnt_reg <= '0;
        end else begin
          q_reg   <= '0;
          rem_reg <= {1'b0, bus.P[PW-1:W]};
          dvd_reg <= bus.P[W-1:0];
          cnt_reg <= CW'(W - 1);
        end
      end else if (state == CALC) begin
        rem_reg <= rem_step;
        dvd_reg <= {dvd_reg[W-2:0], 1'b0};
        q_reg   <= {q_reg[W-2:0], step_bit};
        if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
      end
      if (arm_valid)      out_valid_reg <= 1'b1;
      else if (release_c) out_valid_reg <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_reg;
  assign bus.Q         = q_reg;
  assign bus.R         = rem_reg[W-1:0];
  assign bus.ovf       = ovf_reg;
  assign bus.dbz       = dbz_reg;

endmodule
